// File: rtl/key_conditioner.sv
// ============================================================================
//  Module      : key_conditioner
//  Description : Push-button front end: 2-flop sync, debounce, press/release
//                pulses and optional hold-to-repeat, one channel per key.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module key_conditioner #(
    parameter int NUM_KEYS        = 4,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_raw,
    input  logic [NUM_KEYS-1:0] repeat_en,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_pulse,
    output logic [NUM_KEYS-1:0] key_release
);

    localparam int c_CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_RCNT_W  = (c_RPT_MAX > 1) ? $clog2(c_RPT_MAX) : 1;

    localparam logic [c_CNT_W-1:0]  c_CNT_LAST    = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_RCNT_W-1:0] c_DELAY_LAST  = c_RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [c_RCNT_W-1:0] c_PERIOD_LAST = c_RCNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [0:0] {
        ST_RELEASED = 1'b0,
        ST_PRESSED  = 1'b1
    } key_state_e;

    typedef enum logic [0:0] {
        PH_DELAY  = 1'b0,
        PH_PERIOD = 1'b1
    } rpt_phase_e;

    logic [NUM_KEYS-1:0] s0_d, s0_q;
    logic [NUM_KEYS-1:0] s1_d, s1_q;

    always_comb begin
        s0_d = ACTIVE_LOW ? ~key_raw : key_raw;
        s1_d = s0_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_q <= '0;
            s1_q <= '0;
        end else begin
            s0_q <= s0_d;
            s1_q <= s1_d;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_KEYS; g++) begin : g_key
            logic [c_CNT_W-1:0]  cnt_d, cnt_q;
            logic [c_RCNT_W-1:0] rcnt_d, rcnt_q;
            logic [c_RCNT_W-1:0] w_rpt_last;
            logic                level_d, level_q;
            logic                pulse_d, pulse_q;
            logic                release_d, release_q;
            logic                w_accept;
            key_state_e          state_d, state_q;
            rpt_phase_e          phase_d, phase_q;

            always_comb begin
                cnt_d      = cnt_q;
                level_d    = level_q;
                rcnt_d     = rcnt_q;
                phase_d    = phase_q;
                state_d    = state_q;
                pulse_d    = 1'b0;
                release_d  = 1'b0;
                w_accept   = 1'b0;
                w_rpt_last = (phase_q == PH_DELAY) ? c_DELAY_LAST : c_PERIOD_LAST;

                // Any sample agreeing with the current level restarts the count.
                if (s1_q[g] == level_q) begin
                    cnt_d = '0;
                end else if (cnt_q == c_CNT_LAST) begin
                    cnt_d    = '0;
                    level_d  = s1_q[g];
                    w_accept = 1'b1;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end

                case (state_q)
                    ST_RELEASED: begin
                        rcnt_d  = '0;
                        phase_d = PH_DELAY;
                        if (w_accept && s1_q[g]) begin
                            state_d = ST_PRESSED;
                            pulse_d = 1'b1;
                        end
                    end
                    ST_PRESSED: begin
                        // A release accepted on a repeat edge suppresses the repeat.
                        if (w_accept && !s1_q[g]) begin
                            state_d   = ST_RELEASED;
                            release_d = 1'b1;
                            rcnt_d    = '0;
                            phase_d   = PH_DELAY;
                        end else if (!repeat_en[g]) begin
                            rcnt_d  = '0;
                            phase_d = PH_DELAY;
                        end else if (rcnt_q == w_rpt_last) begin
                            pulse_d = 1'b1;
                            rcnt_d  = '0;
                            phase_d = PH_PERIOD;
                        end else begin
                            rcnt_d = rcnt_q + c_RCNT_W'(1);
                        end
                    end
                    default: state_d = ST_RELEASED;
                endcase
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q     <= '0;
                    rcnt_q    <= '0;
                    level_q   <= 1'b0;
                    pulse_q   <= 1'b0;
                    release_q <= 1'b0;
                    state_q   <= ST_RELEASED;
                    phase_q   <= PH_DELAY;
                end else begin
                    cnt_q     <= cnt_d;
                    rcnt_q    <= rcnt_d;
                    level_q   <= level_d;
                    pulse_q   <= pulse_d;
                    release_q <= release_d;
                    state_q   <= state_d;
                    phase_q   <= phase_d;
                end
            end

            assign key_level[g]   = level_q;
            assign key_pulse[g]   = pulse_q;
            assign key_release[g] = release_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_key_conditioner.sv
// ============================================================================
//  Module      : tb_key_conditioner
//  Description : Directed and random checks of key_conditioner against a
//                sample-window / edge-age reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_key_conditioner;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] key_raw;
    logic [N-1:0] repeat_en;
    logic [N-1:0] key_level;
    logic [N-1:0] key_pulse;
    logic [N-1:0] key_release;

    key_conditioner #(
        .NUM_KEYS(N), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst(rst), .key_raw(key_raw), .repeat_en(repeat_en),
        .key_level(key_level), .key_pulse(key_pulse), .key_release(key_release)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state: last D pre-edge synchronized samples per key,
    // and the edge from which the current hold-to-repeat age is measured.
    logic [N-1:0] m_s0, m_s1, m_level, m_pulse, m_rel;
    logic [D-1:0] hist[N];
    int           hcnt[N];
    int           anchor[N];

    int pq[N][$];
    int rq[N][$];
    int hq[N][$];

    task automatic model_reset();
        m_s0 = '0; m_s1 = '0; m_level = '0; m_pulse = '0; m_rel = '0;
        for (int i = 0; i < N; i++) begin
            hist[i] = '0; hcnt[i] = 0; anchor[i] = cyc;
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] act;
        bit flip, fire;
        int age;
        act = ~key_raw;
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < N; i++) begin
            hist[i] = {hist[i][D-2:0], m_s1[i]};
            if (hcnt[i] < D) hcnt[i]++;
            flip = (hcnt[i] >= D) && (hist[i] == {D{~m_level[i]}});
            age  = cyc - anchor[i];
            fire = m_level[i] && repeat_en[i] && !flip && (age >= RD) && (((age - RD) % RP) == 0);
            if (!m_level[i] || !repeat_en[i]) anchor[i] = cyc;
            m_pulse[i] = (flip && !m_level[i]) || fire;
            m_rel[i]   = flip && m_level[i];
            if (flip) m_level[i] = ~m_level[i];
        end
        m_s1 = m_s0;
        m_s0 = act;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_q(input string tag, input int got[$], input int base, input int exp[$]);
        chk({tag, "_count"}, got.size(), exp.size());
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            chk({tag, "_edge"}, got[i] - base, exp[i]);
    endtask

    task automatic check();
        chk("key_level",   int'(key_level),   int'(m_level));
        chk("key_pulse",   int'(key_pulse),   int'(rst ? '0 : m_pulse));
        chk("key_release", int'(key_release), int'(rst ? '0 : m_rel));
        for (int i = 0; i < N; i++) begin
            if (key_pulse[i] === 1'b1)   pq[i].push_back(cyc);
            if (key_release[i] === 1'b1) rq[i].push_back(cyc);
            if (key_level[i] === 1'b1)   hq[i].push_back(cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_q();
        for (int i = 0; i < N; i++) begin
            pq[i].delete(); rq[i].delete(); hq[i].delete();
        end
    endtask

    initial begin
        int k;
        int e[$];
        rst = 1'b1; key_raw = '1; repeat_en = '0;
        model_reset();
        steps(2);
        chk("rst_outputs", int'({key_level, key_pulse, key_release}), 0);
        rst = 1'b0;
        steps(3);

        // 1: clean press on key 1, no repeat
        clear_q();
        key_raw[1] = 1'b0;
        step(); k = cyc;
        steps(55);
        e = '{5};
        chk_q("s1_pulse", pq[1], k, e);
        chk("s1_level", int'(key_level[1]), 1);

        // 2: bouncy press on key 0
        clear_q();
        key_raw[0] = 1'b0; steps(3);
        key_raw[0] = 1'b1; step();
        key_raw[0] = 1'b0; step(); k = cyc;
        steps(15);
        chk_q("s2_pulse", pq[0], k, e);

        // 3: hold-to-repeat on key 2, release coincides with a repeat edge
        clear_q();
        repeat_en[2] = 1'b1;
        key_raw[2] = 1'b0;
        step(); k = cyc;
        steps(24);
        key_raw[2] = 1'b1;
        steps(20);
        e = '{5, 15, 18, 21, 24, 27};
        chk_q("s3_pulse", pq[2], k, e);
        e = '{30};
        chk_q("s3_release", rq[2], k, e);
        repeat_en[2] = 1'b0;

        // 4: keys 0 and 3 on the same edge
        key_raw = '1; steps(12);
        clear_q();
        key_raw[0] = 1'b0; key_raw[3] = 1'b0;
        step(); k = cyc;
        steps(10);
        e = '{5};
        chk_q("s4_pulse0", pq[0], k, e);
        chk_q("s4_pulse3", pq[3], k, e);
        chk("s4_level", int'(key_level), 9);

        // 5: reset during key 1 debounce, key held through reset
        key_raw = '1; steps(12);
        key_raw[1] = 1'b0;
        steps(3);
        rst = 1'b1;
        model_reset();
        #1;
        check();
        chk("s5_rst_entry", int'({key_level, key_pulse, key_release}), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("s5_rst_hold", int'({key_level, key_pulse, key_release}), 0);
        end
        rst = 1'b0;
        clear_q();
        step(); k = cyc;
        steps(10);
        e = '{5};
        chk_q("s5_pulse", pq[1], k, e);

        // 6: short glitch on key 3
        key_raw = '1; steps(12);
        clear_q();
        key_raw[3] = 1'b0; steps(3);
        key_raw[3] = 1'b1; steps(20);
        chk("s6_pulse",   pq[3].size(), 0);
        chk("s6_release", rq[3].size(), 0);
        chk("s6_level",   hq[3].size(), 0);

        // Random phase: alternating bouncy and calm stretches
        for (int blk = 0; blk < 16; blk++) begin
            int rate;
            rate = (blk % 2 == 0) ? 3 : 40;
            for (int c = 0; c < 100; c++) begin
                for (int i = 0; i < N; i++) begin
                    if ($urandom_range(rate, 0) == 0) key_raw[i] = ~key_raw[i];
                    if ($urandom_range(40, 0) == 0) repeat_en[i] = ~repeat_en[i];
                end
                rst = ($urandom_range(300, 0) == 0);
                if (rst) model_reset();
                step();
            end
        end
        rst = 1'b0;
        steps(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
